// File: rtl/fft_frame_loader.sv
// fft_frame_loader: collects real audio samples into an FFT data memory,
// one complex word per sample, then starts the FFT core and waits for it.
//
// Upstream handshake: a sample transfers on a rising edge where s_valid and
// s_ready are both high. s_ready is registered and is high only in FILL.
// A transferred sample is written to the FFT memory in the following cycle.
module fft_frame_loader #(
    parameter int Nb        = 18,
    parameter int log_depth = 10
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [Nb-1:0]        s_data,
    input  logic [3:0]           cfg_log_depth,
    input  logic                 cfg_direction,
    input  logic                 flush,
    input  logic                 fft_ready,
    input  logic                 fft_done,
    output logic                 fft_start,
    output logic [3:0]           fft_log_depth,
    output logic                 fft_direction,
    output logic                 fft_real_mode,
    output logic [log_depth-1:0] fft_address,
    output logic                 fft_write_enable,
    output logic [2*Nb-1:0]      fft_write_data,
    output logic                 frame_done,
    output logic [15:0]          frame_count,
    output logic [2:0]           dbg_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        DRAIN = 3'd2,
        START = 3'd3,
        BUSY  = 3'd4
    } state_t;

    localparam logic [3:0] MinDepth = 4'd3;
    localparam logic [3:0] MaxDepth = 4'(log_depth);

    state_t                 state_q;
    logic                   s_ready_q;
    logic                   start_q;
    logic                   done_q;
    logic                   wr_en_q;
    logic [log_depth-1:0]   addr_q;
    logic [2*Nb-1:0]        data_q;
    logic [log_depth-1:0]   index_q;
    logic [3:0]             depth_q;
    logic                   dir_q;
    logic [15:0]            count_q;

    logic [3:0]             depth_d;
    logic [log_depth-1:0]   last_idx;
    logic                   accept;

    assign accept = s_valid & s_ready_q;

    // Clamp the requested frame length into the range the memory supports.
    always_comb begin
        depth_d = cfg_log_depth;
        if (cfg_log_depth < MinDepth) begin
            depth_d = MinDepth;
        end else if (cfg_log_depth > MaxDepth) begin
            depth_d = MaxDepth;
        end
    end

    // Index of the final sample of the current frame (N-1).
    always_comb begin
        last_idx = log_depth'((32'd1 << depth_q) - 32'd1);
    end

    // Frame sequencer with registered handshake, write port and FFT control.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            s_ready_q <= 1'b0;
            start_q   <= 1'b0;
            done_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            index_q   <= '0;
            depth_q   <= '0;
            dir_q     <= 1'b0;
            count_q   <= '0;
        end else begin
            wr_en_q <= 1'b0;
            start_q <= 1'b0;
            done_q  <= 1'b0;

            // An accepted sample is always written, even on a flush edge.
            if (accept) begin
                wr_en_q <= 1'b1;
                addr_q  <= index_q;
                data_q  <= {{Nb{1'b0}}, s_data};
                index_q <= index_q + 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (fft_ready) begin
                        depth_q   <= depth_d;
                        dir_q     <= cfg_direction;
                        index_q   <= '0;
                        s_ready_q <= 1'b1;
                        state_q   <= FILL;
                    end
                end
                FILL: begin
                    if (flush) begin
                        index_q   <= '0;
                        s_ready_q <= 1'b0;
                        state_q   <= IDLE;
                    end else if (accept && (index_q == last_idx)) begin
                        s_ready_q <= 1'b0;
                        state_q   <= DRAIN;
                    end
                end
                DRAIN: begin
                    start_q <= 1'b1;
                    state_q <= START;
                end
                START: begin
                    state_q <= BUSY;
                end
                BUSY: begin
                    if (fft_done) begin
                        done_q  <= 1'b1;
                        count_q <= count_q + 16'd1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    s_ready_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign s_ready          = s_ready_q;
    assign fft_start        = start_q;
    assign fft_log_depth    = depth_q;
    assign fft_direction    = dir_q;
    assign fft_real_mode    = 1'b0;
    assign fft_address      = addr_q;
    assign fft_write_enable = wr_en_q;
    assign fft_write_data   = data_q;
    assign frame_done       = done_q;
    assign frame_count      = count_q;
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_fft_frame_loader.sv
// tb_fft_frame_loader: directed frames against a queue-based write model.
module tb_fft_frame_loader;

    localparam int NB = 18;
    localparam int LD = 10;
    localparam int W  = LD + 2 * NB;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            s_valid;
    logic            s_ready;
    logic [NB-1:0]   s_data;
    logic [3:0]      cfg_log_depth;
    logic            cfg_direction;
    logic            flush;
    logic            fft_ready;
    logic            fft_done;
    logic            fft_start;
    logic [3:0]      fft_log_depth;
    logic            fft_direction;
    logic            fft_real_mode;
    logic [LD-1:0]   fft_address;
    logic            fft_write_enable;
    logic [2*NB-1:0] fft_write_data;
    logic            frame_done;
    logic [15:0]     frame_count;
    logic [2:0]      dbg_state;

    fft_frame_loader #(.Nb(NB), .log_depth(LD)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .s_valid          (s_valid),
        .s_ready          (s_ready),
        .s_data           (s_data),
        .cfg_log_depth    (cfg_log_depth),
        .cfg_direction    (cfg_direction),
        .flush            (flush),
        .fft_ready        (fft_ready),
        .fft_done         (fft_done),
        .fft_start        (fft_start),
        .fft_log_depth    (fft_log_depth),
        .fft_direction    (fft_direction),
        .fft_real_mode    (fft_real_mode),
        .fft_address      (fft_address),
        .fft_write_enable (fft_write_enable),
        .fft_write_data   (fft_write_data),
        .frame_done       (frame_done),
        .frame_count      (frame_count),
        .dbg_state        (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int writes_seen = 0;
    int start_cnt = 0;
    int done_cnt = 0;
    int last_start_cyc = 0;
    int last_acc_cyc = 0;
    int model_frames = 0;
    bit expect_no_ready = 0;
    bit prev_start = 0;
    bit prev_done = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int model_depth(input int cfg);
        if (cfg < 3) return 3;
        if (cfg > LD) return LD;
        return cfg;
    endfunction

    // Compare process: every visible write must match the next queued sample.
    always @(negedge clk) begin
        if (reset_n) begin
            if (fft_write_enable) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_write: got addr %0d data %0h expected no write",
                             fft_address, fft_write_data);
                end else begin
                    check("write_addr_data", {8'd0, fft_address, fft_write_data}, {8'd0, exp_q.pop_front()});
                end
                writes_seen++;
            end
            if (fft_start) begin
                check("start_width", 64'(prev_start), 64'd0);
                start_cnt++;
                last_start_cyc = cyc;
            end
            if (frame_done) begin
                check("done_width", 64'(prev_done), 64'd0);
                done_cnt++;
            end
            prev_start = fft_start;
            prev_done  = frame_done;
            if (expect_no_ready) check("s_ready_low", 64'(s_ready), 64'd0);
            check("real_mode", 64'(fft_real_mode), 64'd0);
        end else begin
            prev_start = 1'b0;
            prev_done  = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_samples(input int n, input bit gap, input logic [NB-1:0] base);
        int acc = 0;
        int t = 0;
        bit tog = 0;
        while (acc < n && t < n * 4 + 50) begin
            @(negedge clk);
            t++;
            if (gap && tog) begin
                s_valid = 1'b0;
            end else begin
                s_valid = 1'b1;
                s_data  = base + NB'(acc);
            end
            tog = !tog;
            if (s_valid && s_ready) begin
                exp_q.push_back({LD'(acc), {NB{1'b0}}, s_data});
                last_acc_cyc = cyc;
                acc++;
            end
        end
        if (acc < n) check("accept_timeout", 64'(acc), 64'(n));
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_s_ready"}, 64'(s_ready), 64'd0);
        check({tag, "_fft_start"}, 64'(fft_start), 64'd0);
        check({tag, "_write_enable"}, 64'(fft_write_enable), 64'd0);
        check({tag, "_address"}, 64'(fft_address), 64'd0);
        check({tag, "_write_data"}, 64'(fft_write_data), 64'd0);
        check({tag, "_frame_done"}, 64'(frame_done), 64'd0);
        check({tag, "_frame_count"}, 64'(frame_count), 64'd0);
        check({tag, "_log_depth"}, 64'(fft_log_depth), 64'd0);
        check({tag, "_direction"}, 64'(fft_direction), 64'd0);
    endtask

    task automatic run_frame(input int cfg, input bit dir, input bit gap, input logic [NB-1:0] base);
        int n = 1 << model_depth(cfg);
        int w0 = writes_seen;
        int s0 = start_cnt;
        int d0 = done_cnt;
        cfg_log_depth = 4'(cfg);
        cfg_direction = dir;
        fft_ready = 1'b1;
        send_samples(n, gap, base);
        fft_ready = 1'b0;
        cfg_log_depth = 4'(cfg ^ 5);
        cfg_direction = !dir;
        expect_no_ready = 1'b1;
        check("latched_depth", 64'(fft_log_depth), 64'(model_depth(cfg)));
        check("latched_dir", 64'(fft_direction), 64'(dir));
        for (int i = 0; i < 10 && start_cnt == s0; i++) @(negedge clk);
        check("start_count", 64'(start_cnt - s0), 64'd1);
        check("start_delay", 64'(last_start_cyc - last_acc_cyc), 64'd2);
        repeat (3) @(negedge clk);
        check("start_count_busy", 64'(start_cnt - s0), 64'd1);
        check("depth_hold", 64'(fft_log_depth), 64'(model_depth(cfg)));
        fft_done = 1'b1;
        @(negedge clk);
        fft_done = 1'b0;
        for (int i = 0; i < 5 && done_cnt == d0; i++) @(negedge clk);
        model_frames = (model_frames + 1) % 65536;
        check("done_count", 64'(done_cnt - d0), 64'd1);
        check("frame_count", 64'(frame_count), 64'(model_frames));
        check("write_count", 64'(writes_seen - w0), 64'(n));
        check("exp_q_empty", 64'(exp_q.size()), 64'd0);
        expect_no_ready = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int w;
        int s0;
        int d0;
        reset_n = 1'b0;
        s_valid = 1'b0;
        s_data = '0;
        cfg_log_depth = 4'd0;
        cfg_direction = 1'b0;
        flush = 1'b0;
        fft_ready = 1'b0;
        fft_done = 1'b0;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("no_fill_without_ready", 64'(s_ready), 64'd0);

        // Back-to-back 16 samples 0..15.
        w = writes_seen;
        run_frame(4, 1'b1, 1'b0, 18'h00000);
        check("depth4_writes", 64'(writes_seen - w), 64'd16);
        check("depth4_count", 64'(frame_count), 64'd1);

        // fft_done outside BUSY has no effect.
        d0 = done_cnt;
        fft_done = 1'b1;
        @(negedge clk);
        fft_done = 1'b0;
        repeat (3) @(negedge clk);
        check("done_ignored_idle", 64'(done_cnt - d0), 64'd0);
        check("count_ignored_idle", 64'(frame_count), 64'd1);

        // s_valid toggling every other cycle, negative samples.
        run_frame(4, 1'b0, 1'b1, 18'h3FFF8);

        // Depth clamps.
        w = writes_seen;
        run_frame(15, 1'b1, 1'b0, 18'h00100);
        check("clamp_hi_depth", 64'(fft_log_depth), 64'd10);
        check("clamp_hi_writes", 64'(writes_seen - w), 64'd1024);
        w = writes_seen;
        run_frame(1, 1'b0, 1'b0, 18'h00200);
        check("clamp_lo_depth", 64'(fft_log_depth), 64'd3);
        check("clamp_lo_writes", 64'(writes_seen - w), 64'd8);

        // Flush on the edge that accepts the 5th sample.
        s0 = start_cnt;
        w = writes_seen;
        cfg_log_depth = 4'd4;
        fft_ready = 1'b1;
        send_samples(4, 1'b0, 18'h00300);
        fft_ready = 1'b0;
        s_valid = 1'b1;
        s_data = 18'h00304;
        flush = 1'b1;
        check("flush_ready", 64'(s_ready), 64'd1);
        exp_q.push_back({LD'(4), {NB{1'b0}}, s_data});
        @(negedge clk);
        flush = 1'b0;
        s_valid = 1'b0;
        repeat (8) @(negedge clk);
        check("flush_no_start", 64'(start_cnt - s0), 64'd0);
        check("flush_writes", 64'(writes_seen - w), 64'd5);
        check("flush_exp_empty", 64'(exp_q.size()), 64'd0);
        check("flush_idle_ready", 64'(s_ready), 64'd0);
        run_frame(4, 1'b1, 1'b0, 18'h00400);

        // Asynchronous reset in the middle of FILL.
        cfg_log_depth = 4'd4;
        fft_ready = 1'b1;
        send_samples(7, 1'b0, 18'h00500);
        fft_ready = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("midfill_reset");
        check("midfill_exp_empty", 64'(exp_q.size()), 64'd0);
        model_frames = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_reset_no_fill", 64'(s_ready), 64'd0);
        check("post_reset_count", 64'(frame_count), 64'd0);
        run_frame(4, 1'b0, 1'b0, 18'h00600);

        // Three completed frames after a fresh reset.
        reset_n = 1'b0;
        #1;
        check_all_zero("second_reset");
        model_frames = 0;
        @(negedge clk);
        reset_n = 1'b1;
        d0 = done_cnt;
        run_frame(3, 1'b0, 1'b0, 18'h00700);
        run_frame(3, 1'b1, 1'b0, 18'h00710);
        run_frame(3, 1'b0, 1'b1, 18'h00720);
        check("three_done_pulses", 64'(done_cnt - d0), 64'd3);
        check("three_frame_count", 64'(frame_count), 64'd3);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_frame_loader.md
FFT_FRAME_LOADER -- requirements
Module: fft_frame_loader

Interface
REQ-001 SHALL have parameter Nb, default 18, meaning sample width in bits per real/imag component.
REQ-002 SHALL have parameter log_depth, default 10, meaning log2 of the maximum FFT frame length.
REQ-003 SHALL have port clk  input  1  the single clock; all logic is on the rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port s_valid  input  1  upstream sample valid.
REQ-006 SHALL have port s_ready  output  1  sample accepted when s_valid and s_ready are both high at a rising edge.
REQ-007 SHALL have port s_data  input  Nb  signed real audio sample.
REQ-008 SHALL have port cfg_log_depth  input  4  requested frame log2 length.
REQ-009 SHALL have port cfg_direction  input  1  FFT direction request.
REQ-010 SHALL have port flush  input  1  synchronous abort of a partially filled frame.
REQ-011 SHALL have port fft_ready  input  1  FFT core idle.
REQ-012 SHALL have port fft_done  input  1  FFT core finished the transform.
REQ-013 SHALL have port fft_start  output  1  one-cycle start pulse to the FFT core.
REQ-014 SHALL have port fft_log_depth  output  4  latched frame log2 length.
REQ-015 SHALL have port fft_direction  output  1  latched direction.
REQ-016 SHALL have port fft_real_mode  output  1  constant 0 (complex mode).
REQ-017 SHALL have port fft_address  output  log_depth  write address into the FFT data memory.
REQ-018 SHALL have port fft_write_enable  output  1  write strobe.
REQ-019 SHALL have port fft_write_data  output  2*Nb  {imag, real}; imag is 0, real is the sample.
REQ-020 SHALL have port frame_done  output  1  one-cycle pulse when a transform completes.
REQ-021 SHALL have port frame_count  output  16  count of completed frames.

Function
REQ-022 SHALL implement the states IDLE, FILL, DRAIN, START and BUSY.
REQ-023 In IDLE, s_ready SHALL be 0; when fft_ready=1, the block SHALL latch cfg_log_depth (clamped to the range 3..log_depth) and cfg_direction, clear the sample index, and enter FILL.
REQ-024 In FILL, s_ready SHALL be 1; each accepted sample SHALL produce exactly one write in the following cycle, with fft_write_enable=1, fft_address=index and fft_write_data={Nb'0, s_data}; the index SHALL then increment.
REQ-025 On acceptance of sample N-1 (N = 1<<latched depth), the block SHALL enter DRAIN with s_ready=0; the last write SHALL occur in the DRAIN cycle.
REQ-026 DRAIN SHALL be followed by START, where fft_start=1 for exactly one cycle; the block SHALL then enter BUSY.
REQ-027 In BUSY, s_ready SHALL be 0; when fft_done=1 the block SHALL pulse frame_done for one cycle, increment frame_count (wrapping from 65535 to 0), and return to IDLE.
REQ-028 fft_write_enable SHALL be 0 whenever no sample was accepted at the previous edge; a stalled s_valid SHALL insert gaps and SHALL NOT drop or duplicate writes.
REQ-029 In FILL, flush=1 SHALL return the block to IDLE at the next edge with the index cleared; if a sample is accepted on that same edge, it SHALL still be written, but no fft_start SHALL follow.
REQ-030 flush SHALL be ignored in DRAIN, START and BUSY.
REQ-031 fft_log_depth and fft_direction SHALL hold their latched values from the IDLE->FILL transition until the next such transition.
REQ-032 fft_done SHALL be ignored outside BUSY.

Reset
REQ-033 reset_n=0 SHALL immediately force state IDLE and set all outputs to 0 (s_ready, fft_start, fft_write_enable, fft_address, fft_write_data, frame_done, frame_count, fft_log_depth, fft_direction), including when asserted mid-FILL or mid-BUSY.
REQ-034 After reset_n rises, the first action SHALL be an IDLE->FILL transition only when fft_ready=1.

Verification
REQ-035 The bench SHALL cover: cfg_log_depth=4, 16 back-to-back samples 0..15 -> writes at addresses 0..15 with data=sample, a single fft_start 2 cycles after the last accept, and no s_ready until fft_done.
REQ-036 The bench SHALL cover: s_valid toggling every other cycle at depth 4 -> exactly 16 writes, in order, with no duplicates.
REQ-037 The bench SHALL cover: cfg_log_depth=15 with log_depth=10 -> fft_log_depth=10 and 1024 writes; cfg_log_depth=1 -> fft_log_depth=3 and 8 writes.
REQ-038 The bench SHALL cover: flush after 5 samples -> no fft_start, followed by a full new frame whose writes start at address 0.
REQ-039 The bench SHALL cover: reset_n pulsed low mid-FILL -> all outputs are 0 in the same cycle, and the next frame starts at address 0 with frame_count=0.
REQ-040 The bench SHALL cover: fft_done asserted in BUSY three times -> three frame_done pulses and frame_count=3.
